// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result bundle and start/busy/done handshake for alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             alu_start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_AI;
  logic [WIDTH-1:0] alu_BI;
  logic             alu_carry;
  logic             alu_DAA;
  logic             alu_busy;
  logic             alu_done;
  logic [WIDTH-1:0] alu_Y;
  logic [7:0]       alu_flags;

  modport master (
    output alu_start, alu_ctrl, alu_AI, alu_BI, alu_carry, alu_DAA,
    input  alu_busy, alu_done, alu_Y, alu_flags
  );

  modport slave (
    input  alu_start, alu_ctrl, alu_AI, alu_BI, alu_carry, alu_DAA,
    output alu_busy, alu_done, alu_Y, alu_flags
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered multi-cycle ALU with N/V/Z/C flags
// ALU_BCD_EN compiles in nibble-serial decimal SUM/SUB (DEC state); otherwise alu_DAA is ignored.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam logic [3:0] OP_SUM = 4'd0, OP_OR  = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3;
  localparam logic [3:0] OP_LSR = 4'd4, OP_ASL = 4'd5, OP_ROR = 4'd6, OP_ROL = 4'd7;
  localparam logic [3:0] OP_SUB = 4'd8;

`ifdef ALU_BCD_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DEC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC} state_t;
`endif

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_a, r_b, r_y;
  logic [3:0]       r_op;
  logic             r_c, r_done;
  logic [7:0]       r_flags;

  logic             w_accept, w_fin, w_arith, w_c, w_v;
  logic [WIDTH-1:0] w_bp, w_y, w_y_fin;
  logic [WIDTH:0]   w_sum;
  logic [7:0]       w_fl_fin;

  assign w_accept = (r_state == S_IDLE) & bus.alu_start;
  assign w_arith  = (r_op == OP_SUM) | (r_op == OP_SUB);

  always_comb begin
    w_bp  = (r_op == OP_SUB) ? ~r_b : r_b;
    w_sum = {1'b0, r_a} + {1'b0, w_bp} + {{WIDTH{1'b0}}, r_c};
    w_v   = (r_a[WIDTH-1] == w_bp[WIDTH-1]) & (w_sum[WIDTH-1] != r_a[WIDTH-1]);
    w_y   = r_a;
    w_c   = 1'b0;
    case (r_op)
      OP_SUM, OP_SUB: begin w_y = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; end
      OP_OR:  w_y = r_a | r_b;
      OP_XOR: w_y = r_a ^ r_b;
      OP_AND: w_y = r_a & r_b;
      OP_LSR: begin w_y = {1'b0, r_a[WIDTH-1:1]};  w_c = r_a[0];       end
      OP_ASL: begin w_y = {r_a[WIDTH-2:0], 1'b0};  w_c = r_a[WIDTH-1]; end
      OP_ROR: begin w_y = {r_c, r_a[WIDTH-1:1]};   w_c = r_a[0];       end
      OP_ROL: begin w_y = {r_a[WIDTH-2:0], r_c};   w_c = r_a[WIDTH-1]; end
      default: ;
    endcase
  end

`ifdef ALU_BCD_EN
  localparam int NDIG = WIDTH / 4;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [CW-1:0]    r_cnt;
  logic             r_dcy;
  logic [WIDTH-1:0] r_acc, w_acc_nx;
  logic [3:0]       w_da, w_db, w_dig;
  logic [4:0]       w_s;
  logic             w_dcy_nx, w_last, w_dec_req;

  assign w_dec_req = bus.alu_DAA & ((bus.alu_ctrl == OP_SUM) | (bus.alu_ctrl == OP_SUB));
  assign w_last    = (r_cnt == CW'(NDIG - 1));

  // r_dcy is a carry in both directions: for SUB, 1 means no borrow
  always_comb begin
    w_da = 4'(r_a >> {r_cnt, 2'b00});
    w_db = 4'(r_b >> {r_cnt, 2'b00});
    if (r_op == OP_SUB) begin
      w_s      = {1'b0, w_da} - {1'b0, w_db} - {4'b0000, ~r_dcy};
      w_dcy_nx = ~w_s[4];
      w_dig    = w_s[4] ? (w_s[3:0] + 4'd10) : w_s[3:0];
    end else begin
      w_s      = {1'b0, w_da} + {1'b0, w_db} + {4'b0000, r_dcy};
      w_dcy_nx = (w_s > 5'd9);
      w_dig    = w_dcy_nx ? (w_s[3:0] + 4'd6) : w_s[3:0];
    end
    w_acc_nx = WIDTH'({w_dig, r_acc} >> 4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_dcy <= 1'b0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_dcy <= bus.alu_carry;
      r_acc <= '0;
    end else if (r_state == S_DEC) begin
      r_cnt <= r_cnt + CW'(1);
      r_dcy <= w_dcy_nx;
      r_acc <= w_acc_nx;
    end
  end
`else
  logic w_unused_daa;
  assign w_unused_daa = bus.alu_DAA;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_fin      = 1'b0;
    w_y_fin    = w_y;
    w_fl_fin   = {w_y[WIDTH-1], w_arith & w_v, 4'b0000, (w_y == '0), w_c};
    case (r_state)
      S_IDLE: begin
`ifdef ALU_BCD_EN
        if (bus.alu_start) w_state_nx = w_dec_req ? S_DEC : S_EXEC;
`else
        if (bus.alu_start) w_state_nx = S_EXEC;
`endif
      end
      S_EXEC: begin
        w_state_nx = S_IDLE;
        w_fin      = 1'b1;
      end
`ifdef ALU_BCD_EN
      S_DEC: begin
        w_y_fin  = w_acc_nx;
        w_fl_fin = {w_acc_nx[WIDTH-1], w_v, 4'b0000, (w_acc_nx == '0), w_dcy_nx};
        if (w_last) begin
          w_state_nx = S_IDLE;
          w_fin      = 1'b1;
        end
      end
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_flags <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_fin;
      if (w_fin) begin
        r_y     <= w_y_fin;
        r_flags <= w_fl_fin;
      end
      if (w_accept) begin
        r_a  <= bus.alu_AI;
        r_b  <= bus.alu_BI;
        r_c  <= bus.alu_carry;
        r_op <= bus.alu_ctrl;
      end
    end
  end

  assign bus.alu_busy  = (r_state != S_IDLE);
  assign bus.alu_done  = r_done;
  assign bus.alu_Y     = r_y;
  assign bus.alu_flags = r_flags;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH 8 and 16), behavioural model plus directed literals
module tb_alu_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8.slave));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));

`ifdef ALU_BCD_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] y;
    logic [7:0]  f;
    int          lat;
  } res_t;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // lat = edges after the accepting edge until the one that raises done
  function automatic res_t model(input int w, input int op, input int a, input int b,
                                 input int c, input int daa);
    int mask, msb, y, cy, v, bp, s, cc;
    res_t r;
    mask = (1 << w) - 1;
    msb  = 1 << (w - 1);
    y = a; cy = 0; v = 0; bp = b;
    case (op)
      0, 8: begin
        if (op == 8) bp = ~b & mask;
        s  = a + bp + c;
        y  = s & mask;
        cy = (s >> w) & 1;
        v  = (((a ^ bp) & msb) == 0 && ((y ^ a) & msb) != 0) ? 1 : 0;
      end
      1: y = a | b;
      2: y = a ^ b;
      3: y = a & b;
      4: begin y = a >> 1;                  cy = a & 1;            end
      5: begin y = (a << 1) & mask;         cy = (a >> (w-1)) & 1; end
      6: begin y = (a >> 1) | (c << (w-1)); cy = a & 1;            end
      7: begin y = ((a << 1) | c) & mask;   cy = (a >> (w-1)) & 1; end
      default: y = a;
    endcase
    r.lat = 1;
    if (BCD && daa != 0 && (op == 0 || op == 8)) begin
      cc = c;
      y  = 0;
      for (int k = 0; k < w / 4; k++) begin
        int da, db, d;
        da = (a >> (4 * k)) & 15;
        db = (b >> (4 * k)) & 15;
        if (op == 0) begin
          d = da + db + cc; cc = 0;
          if (d > 9) begin d = d + 6; cc = 1; end
        end else begin
          d = da - db - (1 - cc); cc = 1;
          if (d < 0) begin d = d + 10; cc = 0; end
        end
        y = y | ((d & 15) << (4 * k));
      end
      cy    = cc;
      r.lat = w / 4;
    end
    r.y = y[15:0];
    r.f = {(y & msb) != 0, v[0], 4'b0000, y == 0, cy[0]};
    return r;
  endfunction

  // cycle-level expectation for the 8-bit instance
  int   m_rem;
  logic m_done;
  logic [7:0] m_y, m_f;
  res_t m_pend, t_nx;

  always @(posedge clk) begin
    if (reset) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_y    <= '0;
      m_f    <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_y    <= m_pend.y[7:0];
          m_f    <= m_pend.f;
        end
      end else if (b8.alu_start === 1'b1) begin
        t_nx   = model(8, int'(b8.alu_ctrl), int'(b8.alu_AI), int'(b8.alu_BI),
                       int'(b8.alu_carry), int'(b8.alu_DAA));
        m_pend <= t_nx;
        m_rem  <= t_nx.lat;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy8",  32'(b8.alu_busy),  32'(m_rem > 0));
      chk("done8",  32'(b8.alu_done),  32'(m_done));
      chk("y8",     32'(b8.alu_Y),     32'(m_y));
      chk("flags8", 32'(b8.alu_flags), 32'(m_f));
    end
  end

  task automatic run_op(input int w, input int op, input int a, input int b, input int c,
                        input int d, input int ey, input int ef, input int ecnt, input string nm);
    int cnt;
    logic bsy, dn;
    cnt = 0;
    @(negedge clk);
    bsy = (w == 8) ? b8.alu_busy : b16.alu_busy;
    while (bsy && cnt < 20) begin
      @(negedge clk);
      cnt++;
      bsy = (w == 8) ? b8.alu_busy : b16.alu_busy;
    end
    if (w == 8) begin
      b8.alu_start = 1'b1; b8.alu_ctrl = 4'(op); b8.alu_AI = 8'(a); b8.alu_BI = 8'(b);
      b8.alu_carry = 1'(c); b8.alu_DAA = 1'(d);
    end else begin
      b16.alu_start = 1'b1; b16.alu_ctrl = 4'(op); b16.alu_AI = 16'(a); b16.alu_BI = 16'(b);
      b16.alu_carry = 1'(c); b16.alu_DAA = 1'(d);
    end
    @(negedge clk);
    b8.alu_start  = 1'b0;
    b16.alu_start = 1'b0;
    cnt = 1;
    dn  = (w == 8) ? b8.alu_done : b16.alu_done;
    while (!dn && cnt < 20) begin
      @(negedge clk);
      cnt++;
      dn = (w == 8) ? b8.alu_done : b16.alu_done;
    end
    chk({nm, "_lat"},   32'(cnt), 32'(ecnt));
    chk({nm, "_y"},     (w == 8) ? 32'(b8.alu_Y) : 32'(b16.alu_Y), 32'(ey));
    chk({nm, "_flags"}, (w == 8) ? 32'(b8.alu_flags) : 32'(b16.alu_flags), 32'(ef));
  endtask

  res_t r;

  initial begin
    reset = 1'b1;
    b8.alu_start = 1'b0;  b8.alu_ctrl = '0;  b8.alu_AI = '0;  b8.alu_BI = '0;
    b8.alu_carry = 1'b0;  b8.alu_DAA = 1'b0;
    b16.alu_start = 1'b0; b16.alu_ctrl = '0; b16.alu_AI = '0; b16.alu_BI = '0;
    b16.alu_carry = 1'b0; b16.alu_DAA = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(b8.alu_busy),   0);
    chk("rst_done",  32'(b8.alu_done),   0);
    chk("rst_y",     32'(b8.alu_Y),      0);
    chk("rst_flags", 32'(b16.alu_flags), 0);
    cmp_en = 1'b1;
    reset  = 1'b0;

    r = model(8, 0, 'h7F, 'h01, 0, 0);
    chk("pin_sum_y", 32'(r.y), 'h80);
    chk("pin_sum_f", 32'(r.f), 'hC0);
    r = model(8, 7, 'h80, 0, 1, 0);
    chk("pin_rol_f", 32'(r.f), 'h01);
    r = model(8, 8, 'h12, 'h21, 1, 1);
`ifdef ALU_BCD_EN
    chk("pin_dsub_y", 32'(r.y), 'h91);
`else
    chk("pin_dsub_y", 32'(r.y), 'hF1);
`endif

    run_op(8, 0, 'h7F, 'h01, 0, 0, 'h80, 'hC0, 2, "sum_ovf");
    run_op(8, 8, 'h00, 'h01, 1, 0, 'hFF, 'h80, 2, "sub_brw");
    run_op(8, 8, 'h05, 'h05, 1, 0, 'h00, 'h03, 2, "sub_zero");
    run_op(8, 6, 'h01, 'h00, 1, 0, 'h80, 'h81, 2, "ror");
    run_op(8, 5, 'h80, 'h00, 0, 0, 'h00, 'h03, 2, "asl");
    run_op(8, 9, 'h00, 'h55, 1, 0, 'h00, 'h02, 2, "op9");
    run_op(16, 0, 'hFFFF, 'h0001, 0, 0, 'h0000, 'h03, 2, "sum16");
`ifdef ALU_BCD_EN
    run_op(8, 0, 'h58, 'h46, 0, 1, 'h04, 'h41, 3, "dsum");
    run_op(8, 8, 'h12, 'h21, 1, 1, 'h91, 'h80, 3, "dsub");
    run_op(16, 0, 'h9999, 'h0001, 0, 1, 'h0000, 'h03, 5, "dsum16");
`else
    run_op(8, 0, 'h58, 'h46, 0, 1, 'h9E, 'hC0, 2, "dsum");
    run_op(8, 8, 'h12, 'h21, 1, 1, 'hF1, 'h80, 2, "dsub");
    run_op(16, 0, 'h9999, 'h0001, 0, 1, 'h999A, 'h80, 2, "dsum16");
`endif

    // reset while an operation is in flight
    @(negedge clk);
    b8.alu_start = 1'b1; b8.alu_ctrl = 4'd0; b8.alu_AI = 8'h99; b8.alu_BI = 8'h01;
    b8.alu_carry = 1'b0; b8.alu_DAA = 1'b1;
    @(negedge clk);
    b8.alu_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_done", 32'(b8.alu_done), 0);
    chk("abort_y",    32'(b8.alu_Y),    0);
    @(negedge clk);
    chk("abort_done2", 32'(b8.alu_done), 0);

    // start held high: only idle/done-cycle starts may be taken
    for (int i = 0; i < 40; i++) begin
      b8.alu_start = 1'b1;
      b8.alu_ctrl  = 4'($urandom_range(0, 15));
      b8.alu_AI    = 8'($urandom);
      b8.alu_BI    = 8'($urandom);
      b8.alu_carry = 1'($urandom);
      b8.alu_DAA   = 1'($urandom);
      @(negedge clk);
    end

    for (int i = 0; i < 500; i++) begin
      b8.alu_start = ($urandom_range(0, 3) != 0);
      b8.alu_ctrl  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 1) * 8) : 4'($urandom_range(0, 15));
      b8.alu_AI    = 8'($urandom);
      b8.alu_BI    = 8'($urandom);
      b8.alu_carry = 1'($urandom);
      b8.alu_DAA   = ($urandom_range(0, 3) != 0);
      reset        = ((i % 97) == 50);
      @(negedge clk);
    end
    b8.alu_start = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      int op, a, b, c, d;
      op = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 1) * 8 : $urandom_range(0, 15);
      a  = $urandom_range(0, 'hFFFF);
      b  = $urandom_range(0, 'hFFFF);
      c  = $urandom_range(0, 1);
      d  = $urandom_range(0, 1);
      r  = model(16, op, a, b, c, d);
      run_op(16, op, a, b, c, d, int'(r.y), int'(r.f), r.lat + 1, "rnd16");
    end

    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
